// File: rtl/multi_channel_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_controller_if
// Brief    : Request/response bus bundle for the multi-channel controller.
// Revision : 1.0 - initial release
// ============================================================================
interface multi_channel_controller_if #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]            req_valid;
    logic [NUM_CH-1:0]            req_ready;
    logic [NUM_CH*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_CH*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_CH-1:0]            req_wr;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [CH_W-1:0]              rsp_ch;
    logic                         rsp_wr;
    logic [DATA_WIDTH-1:0]        rsp_rdata;

    modport master (
        output req_valid, req_addr, req_wdata, req_wr, rsp_ready,
        input  req_ready, rsp_valid, rsp_ch, rsp_wr, rsp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_wr, rsp_ready,
        output req_ready, rsp_valid, rsp_ch, rsp_wr, rsp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/multi_channel_controller.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_controller
// Brief    : Round-robin multi-channel request arbiter with fixed-latency
//            processing, held response and saturating statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module multi_channel_controller #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int LATENCY    = 3
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    multi_channel_controller_if.slave bus,
    input  wire logic                 stats_clr,
    output logic [31:0]               busy_cycles,
    output logic [15:0]               req_count
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_PW = CH_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CH_W-1:0]         rr_ptr_q;
    logic [7:0]              cnt_q;
    logic [CH_W-1:0]         ch_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    wr_q;
    logic                    rsp_valid_q;
    logic [CH_W-1:0]         rsp_ch_q;
    logic                    rsp_wr_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic [31:0]             busy_q;
    logic [15:0]             reqs_q;

    logic                    w_found;
    logic [CH_W-1:0]         w_grant;
    logic [c_PW-1:0]         w_idx;
    logic                    w_hs;
    logic [CH_W-1:0]         w_ptr_next;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_wdata;

    // Rotating priority search: first valid channel at or above rr_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = c_PW'({1'b0, rr_ptr_q}) + c_PW'(k);
            if (w_idx >= c_PW'(NUM_CH)) begin
                w_idx = w_idx - c_PW'(NUM_CH);
            end
            if (!w_found && bus.req_valid[w_idx[CH_W-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_idx[CH_W-1:0];
            end
        end
    end

    assign w_ptr_next  = (w_grant == CH_W'(NUM_CH - 1)) ? '0 : w_grant + CH_W'(1);
    assign w_sel_addr  = bus.req_addr[int'(w_grant) * ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_wdata = bus.req_wdata[int'(w_grant) * DATA_WIDTH +: DATA_WIDTH];
    assign w_hs        = |(bus.req_valid & bus.req_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // req_ready is gated by rst so it reads all-zero for the whole reset pulse.
    always_comb begin
        state_d       = state_q;
        bus.req_ready = '0;
        case (state_q)
            IDLE: begin
                if (w_found && !rst) begin
                    bus.req_ready[w_grant] = 1'b1;
                    state_d                = PROC;
                end
            end
            PROC: begin
                if (cnt_q <= 8'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            ch_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_ch_q    <= '0;
            rsp_wr_q    <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_hs) begin
                        ch_q     <= w_grant;
                        addr_q   <= w_sel_addr;
                        wdata_q  <= w_sel_wdata;
                        wr_q     <= bus.req_wr[w_grant];
                        cnt_q    <= 8'(LATENCY);
                        rr_ptr_q <= w_ptr_next;
                    end
                end
                PROC: begin
                    if (cnt_q > 8'd1) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        cnt_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_ch_q    <= ch_q;
                        rsp_wr_q    <= wr_q;
                        rsp_rdata_q <= wr_q ? '0 : (DATA_WIDTH'(addr_q) ^ wdata_q);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    cnt_q       <= '0;
                end
            endcase
        end
    end

    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            reqs_q <= '0;
        end else if (stats_clr) begin
            busy_q <= '0;
            reqs_q <= '0;
        end else begin
            if ((state_q != IDLE) && (busy_q != 32'hFFFF_FFFF)) begin
                busy_q <= busy_q + 32'd1;
            end
            if (w_hs && (reqs_q != 16'hFFFF)) begin
                reqs_q <= reqs_q + 16'd1;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_ch    = rsp_ch_q;
    assign bus.rsp_wr    = rsp_wr_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign busy_cycles   = busy_q;
    assign req_count     = reqs_q;

endmodule
`default_nettype wire

// File: doc/multi_channel_controller.md
MULTI_CHANNEL_CONTROLLER -- requirements
Module: multi_channel_controller

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of request channels (legal range 1..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, request address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, data width; ADDR_WIDTH <= DATA_WIDTH.
REQ-004 SHALL have parameter LATENCY, default 3, processing delay in cycles (legal range 1..255).
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 SHALL define CH_W = max(1, clog2(NUM_CH)).
REQ-007 SHALL have port clk, input, 1, rising-edge clock.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port req_valid, input, NUM_CH, per-channel request valid.
REQ-010 SHALL have port req_ready, output, NUM_CH, per-channel accept strobe.
REQ-011 SHALL have port req_addr, input, NUM_CH*ADDR_WIDTH; channel i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-012 SHALL have port req_wdata, input, NUM_CH*DATA_WIDTH, packed per channel in the same way as req_addr.
REQ-013 SHALL have port req_wr, input, NUM_CH, per-channel select: 1 = write, 0 = read.
REQ-014 SHALL have port rsp_valid, output, 1, response valid.
REQ-015 SHALL have port rsp_ready, input, 1, response accept.
REQ-016 SHALL have port rsp_ch, output, CH_W, channel index of the response.
REQ-017 SHALL have port rsp_wr, output, 1, echo of the req_wr value of the accepted request.
REQ-018 SHALL have port rsp_rdata, output, DATA_WIDTH, read data.
REQ-019 SHALL have port stats_clr, input, 1, synchronous clear of the statistics counters.
REQ-020 SHALL have port busy_cycles, output, 32, count of non-IDLE cycles.
REQ-021 SHALL have port req_count, output, 16, count of accepted requests.

Function
REQ-022 SHALL implement FSM states IDLE, PROC and RESP; any illegal encoding SHALL return to IDLE on the next clock.
REQ-023 SHALL, in IDLE with any req_valid high, grant the first valid channel found searching upward from rr_ptr, modulo NUM_CH.
REQ-024 SHALL drive req_ready combinationally, one-hot on the granted channel, only in IDLE; otherwise all zero.
REQ-025 SHALL, on a handshake (req_valid[g] and req_ready[g]), capture channel g's addr, wdata and wr, load cnt = LATENCY, enter PROC, and set rr_ptr = (g+1) mod NUM_CH.
REQ-026 SHALL, in PROC, decrement cnt while cnt > 1 and enter RESP when cnt = 1, so that rsp_valid first rises exactly LATENCY+1 cycles after the handshake cycle.
REQ-027 SHALL, in RESP, hold rsp_valid, rsp_ch, rsp_wr and rsp_rdata stable until rsp_ready is high; on that cycle it SHALL return to IDLE.
REQ-028 SHALL drive rsp_rdata = (zero-extended captured addr) XOR captured wdata for reads, and 0 for writes.
REQ-029 SHALL keep rsp_valid low in IDLE and PROC, and SHALL NOT accept a new request in the cycle in which a response completes.
REQ-030 SHALL increment busy_cycles each cycle the state is not IDLE, saturating at 0xFFFFFFFF.
REQ-031 SHALL increment req_count once per handshake, saturating at 0xFFFF.
REQ-032 SHALL give stats_clr priority over a same-cycle increment: both counters become 0.
REQ-033 SHALL ignore changes to a channel's req_* inputs after its handshake.
REQ-034 SHALL, with NUM_CH = 1, always grant channel 0 and drive rsp_ch = 0.

Reset
REQ-035 SHALL, while rst is high, asynchronously force state = IDLE, rr_ptr = 0, cnt = 0, rsp_valid = 0, rsp_ch = 0, rsp_wr = 0, rsp_rdata = 0, busy_cycles = 0 and req_count = 0; req_ready SHALL be all zero.
REQ-036 SHALL, on reset asserted mid-PROC or mid-RESP, drop the in-flight request with no response issued; after reset release, the first grant SHALL be to the lowest-index valid channel.

Verification
REQ-037 SHALL cover a single read: ch1 addr=0x10, wdata=0xFF, rsp_ready=1 -> rsp_valid 4 cycles after the handshake, rsp_ch=1, rsp_rdata=0xEF, rsp_wr=0.
REQ-038 SHALL cover a write on ch2 -> rsp_wr=1, rsp_rdata=0; req_count goes 0->1.
REQ-039 SHALL cover round-robin: all four channels valid continuously -> grant order 0,1,2,3,0; each req_ready pulse is one-hot.
REQ-040 SHALL cover backpressure: rsp_ready held low for 5 cycles -> rsp_* held stable, req_ready stays zero, busy_cycles keeps incrementing.
REQ-041 SHALL cover reset mid-PROC: rst pulsed on the 2nd PROC cycle -> no rsp_valid, counters = 0, next grant to channel 0.
REQ-042 SHALL cover stats_clr asserted in a handshake cycle -> req_count = 0 on the next cycle, not 1.
